// File: rtl/uart_tx_frame.sv
// UART transmitter: serializes one byte per accepted request as start, LSB-first data,
// optional even/odd parity and one stop bit. One frame bit per clock; TX line is registered.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] p_data_i,
    input  logic                  data_valid_i,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    output logic                  tx_out_o,
    output logic                  busy_o
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    // Outputs come from the next-state decode and are registered, so the line
    // changes on the same edge the FSM moves and never glitches.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = 1'b1;
        busy_d    = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (data_valid_i) begin
                    state_d   = START;
                    shift_d   = p_data_i;
                    par_en_d  = par_en_i;
                    // Parity is fixed at acceptance; odd parity is the inverted XOR.
                    par_bit_d = (^p_data_i) ^ par_typ_i;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            START: begin
                state_d = DATA;
                tx_d    = shift_q[0];
            end

            DATA: begin
                shift_d = shift_q >> 1;
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    tx_d  = shift_q[1];
                end
            end

            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
            end

            STOP: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign tx_out_o = tx_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frames are compared bit-for-bit against
// hand-written line sequences, first transmitted bit in the MSB of each vector.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic       tx_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .p_data_i     (p_data),
        .data_valid_i (data_valid),
        .par_en_i     (par_en),
        .par_typ_i    (par_typ),
        .tx_out_o     (tx_out),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; data_valid = 1'b1; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: tx=%b busy=%b, want tx=1 busy=0", i, tx_out, busy);
            end
        end
        rst = 1'b0; data_valid = 1'b0;
        tick();
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    task automatic test_no_parity();
        logic [10:0] exp_seq;
        exp_seq = 11'b0_0101001011;
        p_data = 8'hA5; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (tx_out !== exp_seq[9-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL nopar_bit[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_seq[9-i]);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL nopar_idle[%0d]: tx=%b busy=%b, want tx=1 busy=0", i, tx_out, busy);
            end
            tick();
        end
    endtask

    task automatic test_even_parity();
        logic [10:0] exp_seq;
        exp_seq = 11'b01110000011;
        p_data = 8'h07; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (tx_out !== exp_seq[10-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL even_bit[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_seq[10-i]);
            end
            tick();
        end
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL even_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        tick();
    endtask

    // Also proves P_DATA/PAR_EN/PAR_TYP are latched: all three change mid-frame.
    task automatic test_odd_parity();
        logic [10:0] exp_seq;
        exp_seq = 11'b01110000001;
        p_data = 8'h07; par_en = 1'b1; par_typ = 1'b1; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (tx_out !== exp_seq[10-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL odd_bit[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_seq[10-i]);
            end
            if (i == 2) begin
                p_data = 8'hFF; par_typ = 1'b0; par_en = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL odd_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a;
        logic [9:0] exp_b;
        exp_a = 10'b0101010101;
        exp_b = 10'b0010101011;
        p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (tx_out !== exp_a[9-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_first[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_a[9-i]);
            end
            if (i == 3) p_data = 8'hAA;
            tick();
        end
        // Valid is still high here, yet exactly one idle-high cycle must appear.
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (tx_out !== exp_b[9-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_second[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_b[9-i]);
            end
            tick();
        end
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        tick();
    endtask

    task automatic test_mid_frame_reset();
        logic [9:0] exp_seq;
        exp_seq = 10'b0001111001;
        p_data = 8'h00; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        tick(); tick(); tick();
        // Data bit 2 is on the line; reset is sampled where data bit 3 would start.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_edge: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (tx_out !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_resume[%0d]: tx=%b busy=%b, want tx=1 busy=0", i, tx_out, busy);
            end
        end
        p_data = 8'h3C; par_en = 1'b0; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (tx_out !== exp_seq[9-i] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_frame[%0d]: tx=%b busy=%b, want tx=%b busy=1", i, tx_out, busy, exp_seq[9-i]);
            end
            tick();
        end
        n_checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: tx=%b busy=%b, want tx=1 busy=0", tx_out, busy);
        end
    endtask

    initial begin
        rst = 1'b1; data_valid = 1'b0; p_data = 8'h00; par_en = 1'b0; par_typ = 1'b0;
        #1;
        test_reset();
        test_no_parity();
        test_even_parity();
        test_odd_parity();
        test_back_to_back();
        test_mid_frame_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

UART transmitter: accepts a parallel byte with a single-cycle valid strobe and serializes it onto the line as a frame: start bit, data LSB-first, optional even/odd parity bit, then one stop bit. It is the transmit-side counterpart of the UART RX path and produces exactly the framing that the RX stop/parity checkers expect. CLK runs at the baud rate, so each frame bit lasts exactly one CLK cycle. A registered FSM drives the line directly, with no combinational path to TX_OUT.

## Interface
- DATA_WIDTH, 8: number of data bits per frame.
- CLK input 1: baud-rate clock, all logic on rising edge.
- RST input 1: synchronous, active-high reset.
- P_DATA input DATA_WIDTH: parallel data, sampled only on frame acceptance.
- Data_Valid input 1: request to send P_DATA; ignored while Busy=1.
- PAR_EN input 1: 1 = append parity bit; sampled on acceptance.
- PAR_TYP input 1: 0 = even parity, 1 = odd parity; sampled on acceptance.
- TX_OUT output 1: serial line, registered, idles high.
- Busy output 1: registered, high while a frame is on the line.

## Operation
- FSM states:
  - IDLE: TX_OUT=1, Busy=0.
  - START: TX_OUT=0.
  - DATA: TX_OUT=data bit, LSB first.
  - PARITY: TX_OUT=parity bit.
  - STOP: TX_OUT=1.
- Transitions:
  - IDLE -> START when Data_Valid=1.
  - START -> DATA always.
  - DATA -> PARITY after DATA_WIDTH bits if the latched PAR_EN=1, otherwise DATA -> STOP.
  - PARITY -> STOP always.
  - STOP -> IDLE always.
- Acceptance happens only in IDLE. On that edge, P_DATA, PAR_EN and PAR_TYP are captured into internal registers. Later changes to these inputs do not affect the frame in flight.
- Bit counter: width $clog2(DATA_WIDTH), counts 0..DATA_WIDTH-1 in DATA and clears on leaving DATA. The shift register shifts right by one per DATA cycle.
- Parity is computed over the latched data word:
  - Even: XOR-reduction of the data.
  - Odd: inverted XOR-reduction of the data.
- Data_Valid seen while Busy=1 is dropped, not queued. A frame needs a fresh Data_Valid in IDLE, so frames are always separated by at least one idle-high cycle.
- Busy=1 in START, DATA, PARITY and STOP.
- Reset values: state IDLE, TX_OUT=1, Busy=0, shift register 0, counter 0, latched PAR_EN/PAR_TYP 0.
- Reset mid-frame: the frame is abandoned. At the edge where RST=1 is sampled, TX_OUT=1 and Busy=0. There is no partial stop bit and no resume. RST takes priority over Data_Valid on the same edge.

## Timing
- Data_Valid sampled high in IDLE at edge k gives:
  - TX_OUT=0 and Busy=1 from edge k.
  - Data bit i on TX_OUT from edge k+1+i.
- Without parity: stop bit from edge k+1+DATA_WIDTH, then IDLE (Busy=0) from edge k+2+DATA_WIDTH. The frame occupies DATA_WIDTH+2 cycles.
- With parity: parity bit from edge k+1+DATA_WIDTH, stop bit at k+2+DATA_WIDTH, then IDLE from k+3+DATA_WIDTH. The frame occupies DATA_WIDTH+3 cycles.
- With Data_Valid held high continuously, the next frame is accepted on the first IDLE cycle. The start-to-start period is DATA_WIDTH+3 cycles without parity and DATA_WIDTH+4 with parity (10 data/stop/start bits + 1 idle for 8-bit data without parity).
- Latency from acceptance to start bit is 0 cycles: the registered TX_OUT changes on the accepting edge.

## Test plan
- Reset: hold RST=1 for 2 cycles with Data_Valid=1 -> TX_OUT=1, Busy=0 throughout; no frame starts until RST=0.
- No parity: P_DATA=8'hA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1; Busy high exactly 10 cycles; line high afterwards.
- Even parity: P_DATA=8'h07, PAR_EN=1, PAR_TYP=0 -> 0,1,1,1,0,0,0,0,0,1,1 (parity=1); Busy high 11 cycles.
- Odd parity: repeat with PAR_TYP=1 -> parity bit 0; change P_DATA to 8'hFF during the DATA bits -> transmitted bits still match 8'h07.
- Back-to-back: Data_Valid held high, P_DATA=8'h55 then 8'hAA (switched mid-frame), PAR_EN=0 -> first frame carries 8'h55; exactly one idle-high cycle; second start bit 11 cycles after the first; second frame carries 8'hAA.
- Mid-frame reset: RST=1 for one cycle during data bit 3 -> TX_OUT=1 and Busy=0 at that edge. A following Data_Valid with P_DATA=8'h3C transmits a complete, correct frame.
